vga_timing_gen: RTL

- Pixel-timing generator that sits directly upstream of the screen controllers (credits, menu, game).
- Produces the hcount/vcount counters and the hsync/vsync/hblnk/vblnk strobes those stages consume as their *_in ports.
- Default timing is 800x600@60 Hz, for a 40 MHz pixel clock.
- All outputs are registered, so downstream stages see glitch-free, mutually aligned signals.

---
 rtl/vga_timing_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-timing generator for the screen-controller chain.
// Produces registered hcount/vcount plus hsync/vsync/hblnk/vblnk, all aligned
// to the same pixel. Default timing is 800x600@60 Hz at a 40 MHz pixel clock.
// Optional build macro VGA_TIMING_FRAME_TICK_EN adds a once-per-frame
// frame_tick output at the first blank pixel of the last visible line.
module vga_timing_gen #(
  parameter int   H_ACT    = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACT    = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk
`ifdef VGA_TIMING_FRAME_TICK_EN
  ,
  output logic        frame_tick
`endif
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  // Counters are 11 bits wide, so neither total may exceed 2048.
  generate
    if (H_TOT > 2048 || V_TOT > 2048) begin : g_bad_total
      $error("vga_timing_gen: H_TOT=%0d / V_TOT=%0d exceed 2048", H_TOT, V_TOT);
    end
  endgenerate

  // Decode boundaries are 12 bits so an end-of-sync value of 2048 still fits.
  localparam logic [11:0] H_ACT_C    = 12'(H_ACT);
  localparam logic [11:0] H_SSTART_C = 12'(H_ACT + H_FP);
  localparam logic [11:0] H_SEND_C   = 12'(H_ACT + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_C    = 12'(V_ACT);
  localparam logic [11:0] V_SSTART_C = 12'(V_ACT + V_FP);
  localparam logic [11:0] V_SEND_C   = 12'(V_ACT + V_FP + V_SYNC);
  localparam logic [10:0] H_LAST_C   = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST_C   = 11'(V_TOT - 1);

  logic [1:0]  rst_sync_q, rst_sync_d;
  logic        advance;
  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic [11:0] h_next_ext, v_next_ext;

  // Release synchroniser: reset asserts at once, deasserts after two edges.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign advance = en & rst_sync_q[1];

  // Next counter values; everything holds when not advancing.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (advance) begin
      if (hcount_q == H_LAST_C) begin
        hcount_d = 11'd0;
        vcount_d = (vcount_q == V_LAST_C) ? 11'd0 : vcount_q + 11'd1;
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end
  end

  assign h_next_ext = {1'b0, hcount_d};
  assign v_next_ext = {1'b0, vcount_d};

  // Strobes decoded from the next counters so they register in step with them.
  // vsync only depends on vcount, so it can only move at the line wrap.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    hblnk_d = hblnk_q;
    vblnk_d = vblnk_q;
    if (advance) begin
      hblnk_d = (h_next_ext >= H_ACT_C);
      vblnk_d = (v_next_ext >= V_ACT_C);
      hsync_d = ((h_next_ext >= H_SSTART_C) && (h_next_ext < H_SEND_C)) ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((v_next_ext >= V_SSTART_C) && (v_next_ext < V_SEND_C)) ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Output registers; async reset drops the frame back to the origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q <= 11'd0;
      vcount_q <= 11'd0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
    end
  end

  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign hblnk  = hblnk_q;
  assign vblnk  = vblnk_q;

`ifdef VGA_TIMING_FRAME_TICK_EN
  localparam logic [10:0] V_TICK_ROW_C = 11'(V_ACT - 1);

  logic frame_tick_q, frame_tick_d;

  // Tick marks the first blank pixel of the last visible line.
  always_comb begin
    frame_tick_d = frame_tick_q;
    if (advance) begin
      frame_tick_d = (h_next_ext == H_ACT_C) && (vcount_d == V_TICK_ROW_C);
    end
  end

  // Frame tick register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_tick_q <= 1'b0;
    else        frame_tick_q <= frame_tick_d;
  end

  assign frame_tick = frame_tick_q;
`endif

endmodule
